// File: rtl/ddr5_phy_config_regfile.sv
// DDR5 PHY config register file: shadow bank written by the host,
// copied into the active bank by a commit that waits for DFI idle.
//
// Ports:
//   clk_i, rst_i            clock, async active-low reset
//   wr_en_i/wr_ready_o      host write handshake (ready only when idle)
//   addr_i, wdata_i         shared read/write address, write data
//   rd_en_i                 read request; rdata_o/rd_valid_o one cycle later
//   err_o                   pulse: accepted write was illegal and dropped
//   commit_req_i            request shadow->active copy
//   dfi_idle_i              commit may apply only while high
//   commit_ack_o            pulse: commit applied this cycle
//   phy_CRC_mode_o          active word0[0]
//   dfi_freq_ratio_o        active word1[1:0]
//   wr_latency_o            active word2
//
// Map: 0 CRC, 1 freq ratio, 2 write latency, 3 STATUS (RO),
//      4.. scratch (shadow only, never copied to outputs).
// STATUS = {commit count, sticky error, commit pending}.

module ddr5_phy_config_regfile #(
  parameter int unsigned pDATA_WIDTH = 8,
  parameter int unsigned pADDR_WIDTH = 3,
  parameter logic        pCRC_MODE   = 1'b1,
  parameter logic [1:0]  pFREQ_RATIO = 2'b00,
  parameter int unsigned pWR_LAT     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  output logic                   wr_ready_o,
  input  logic [pADDR_WIDTH-1:0] addr_i,
  input  logic [pDATA_WIDTH-1:0] wdata_i,
  input  logic                   rd_en_i,
  output logic [pDATA_WIDTH-1:0] rdata_o,
  output logic                   rd_valid_o,
  output logic                   err_o,
  input  logic                   commit_req_i,
  input  logic                   dfi_idle_i,
  output logic                   commit_ack_o,
  output logic                   phy_CRC_mode_o,
  output logic [1:0]             dfi_freq_ratio_o,
  output logic [pDATA_WIDTH-1:0] wr_latency_o
);

  localparam int unsigned NUM_WORDS = 1 << pADDR_WIDTH;
  localparam int unsigned CW        = pDATA_WIDTH - 2;

  typedef logic [pDATA_WIDTH-1:0] word_t;
  typedef logic [pADDR_WIDTH-1:0] addr_t;

  localparam word_t DEF_W0 = word_t'(pCRC_MODE);
  localparam word_t DEF_W1 = word_t'(pFREQ_RATIO);
  localparam word_t DEF_W2 = word_t'(pWR_LAT);

  localparam addr_t A_CRC  = addr_t'(0);
  localparam addr_t A_FREQ = addr_t'(1);
  localparam addr_t A_WLAT = addr_t'(2);
  localparam addr_t A_STAT = addr_t'(3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_APPLY
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  word_t  r_shadow [NUM_WORDS];

  logic          r_act_crc;
  logic [1:0]    r_act_ratio;
  word_t         r_act_lat;

  logic          r_err;
  logic          r_sticky;
  logic [CW-1:0] r_cnt;

  word_t         r_rdata;
  logic          r_rvalid;

  logic  w_is_idle;
  logic  w_ack;
  logic  w_a_crc;
  logic  w_a_freq;
  logic  w_a_stat;
  logic  w_wr_acc;
  logic  w_wr_bad;
  logic  w_wr_ok;
  word_t w_wdata;
  word_t w_status;
  word_t w_rd_word;

  // ---------------- commit FSM ----------------

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_is_idle   = 1'b0;
    w_ack       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_is_idle = 1'b1;
        if (commit_req_i) begin
          w_state_nxt = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (dfi_idle_i) begin
          w_state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        w_ack       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------- write decode ----------------

  assign w_a_crc  = (addr_i == A_CRC);
  assign w_a_freq = (addr_i == A_FREQ);
  assign w_a_stat = (addr_i == A_STAT);

  assign w_wr_acc = wr_en_i & w_is_idle;

  // Ratio 2'b11 has no meaning, so it is rejected
  // rather than silently stored.
  assign w_wr_bad = w_a_stat |
                    (w_a_freq & (wdata_i[1:0] == 2'b11));

  assign w_wr_ok  = w_wr_acc & ~w_wr_bad;

  // Narrow fields store only their defined bits,
  // so upper bits read back as zero.
  always_comb begin
    w_wdata = wdata_i;
    unique case (1'b1)
      w_a_crc:  w_wdata = word_t'(wdata_i[0]);
      w_a_freq: w_wdata = word_t'(wdata_i[1:0]);
      default:  w_wdata = wdata_i;
    endcase
  end

  // ---------------- shadow bank ----------------

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_shadow[i] <= '0;
      end
      r_shadow[0] <= DEF_W0;
      r_shadow[1] <= DEF_W1;
      r_shadow[2] <= DEF_W2;
    end else if (w_wr_ok) begin
      r_shadow[addr_i] <= w_wdata;
    end
  end

  // ---------------- active bank ----------------

  // Writes are blocked outside IDLE, so the shadow
  // is stable while the APPLY copy happens.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_act_crc   <= pCRC_MODE;
      r_act_ratio <= pFREQ_RATIO;
      r_act_lat   <= DEF_W2;
    end else if (w_ack) begin
      r_act_crc   <= r_shadow[A_CRC][0];
      r_act_ratio <= r_shadow[A_FREQ][1:0];
      r_act_lat   <= r_shadow[A_WLAT];
    end
  end

  // ---------------- error / status ----------------

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_wr_acc & w_wr_bad;
    end
  end

  // Sticky error follows the err_o pulse; a commit
  // clears it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sticky <= 1'b0;
    end else if (w_ack) begin
      r_sticky <= 1'b0;
    end else if (r_err) begin
      r_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (w_ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_status = {r_cnt, r_sticky, ~w_is_idle};

  // ---------------- read port ----------------

  // Sampled from pre-write state, so a read and
  // write to one address return the old value.
  assign w_rd_word = w_a_stat ? w_status
                              : r_shadow[addr_i];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= rd_en_i;
      if (rd_en_i) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  // ---------------- outputs ----------------

  assign wr_ready_o       = w_is_idle;
  assign commit_ack_o     = w_ack;
  assign err_o            = r_err;
  assign rdata_o          = r_rdata;
  assign rd_valid_o       = r_rvalid;
  assign phy_CRC_mode_o   = r_act_crc;
  assign dfi_freq_ratio_o = r_act_ratio;
  assign wr_latency_o     = r_act_lat;

endmodule
